// File: rtl/bp_cfg_sequencer.sv
// bp_cfg_sequencer
//   Post-reset configuration sequencer for the core-tile array. After a start
//   request it writes, for every core in order: freeze=1, core ID, start PC.
//   It then waits until every write has been acknowledged, writes freeze=0 to
//   every core, waits again for all acks, and reports done.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   reset_n_i    synchronous active-low reset
//   start_i      begin a sequence (only honoured while idle)
//   start_pc_i   boot PC, captured with start_i
//   cmd_v_o      config write valid           cmd_ready_i  network accepts write
//   cmd_dest_o   target core index            cmd_addr_o   config register address
//   cmd_data_o   write data (zero-extended)   resp_v_i     one write acknowledged
//   busy_o       sequence in progress         done_o       sticky completion flag
module bp_cfg_sequencer #(
  parameter int unsigned num_core_p        = 4,
  parameter int unsigned vaddr_width_p     = 39,
  parameter int unsigned cfg_addr_width_p  = 16,
  parameter int unsigned cfg_data_width_p  = 64,
  parameter int unsigned max_outstanding_p = 4,
  parameter logic [cfg_addr_width_p-1:0] freeze_addr_p  = 16'h0008,
  parameter logic [cfg_addr_width_p-1:0] core_id_addr_p = 16'h0010,
  parameter logic [cfg_addr_width_p-1:0] npc_addr_p     = 16'h0020,
  localparam int unsigned dest_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [vaddr_width_p-1:0]    start_pc_i,
  output logic                        cmd_v_o,
  input  logic                        cmd_ready_i,
  output logic [dest_width_lp-1:0]    cmd_dest_o,
  output logic [cfg_addr_width_p-1:0] cmd_addr_o,
  output logic [cfg_data_width_p-1:0] cmd_data_o,
  input  logic                        resp_v_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned cnt_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [dest_width_lp-1:0] last_idx_lp = dest_width_lp'(num_core_p - 1);
  localparam logic [cnt_width_lp-1:0]  max_cnt_lp  = cnt_width_lp'(max_outstanding_p);

  typedef enum logic [2:0] {
    S_IDLE, S_FRZ, S_CID, S_NPC, S_BAR, S_UNF, S_DRN
  } state_e;

  state_e                      state_q, state_d;
  logic [dest_width_lp-1:0]    idx_q, idx_d;
  logic [vaddr_width_p-1:0]    pc_q, pc_d;
  logic [cnt_width_lp-1:0]     cnt_q, cnt_d;
  logic                        cmd_v_q, cmd_v_d;
  logic [dest_width_lp-1:0]    dest_q, dest_d;
  logic [cfg_addr_width_p-1:0] addr_q, addr_d;
  logic [cfg_data_width_p-1:0] data_q, data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic xfer, resp_ok, last_core;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    done_d  = done_q;

    xfer      = cmd_v_q & cmd_ready_i;
    // An ack with nothing outstanding cannot belong to us; drop it.
    resp_ok   = resp_v_i & (cnt_q != '0);
    last_core = (idx_q == last_idx_lp);

    cnt_d = cnt_q;
    if (xfer && !resp_ok)      cnt_d = cnt_q + cnt_width_lp'(1);
    else if (!xfer && resp_ok) cnt_d = cnt_q - cnt_width_lp'(1);

    case (state_q)
      S_IDLE: if (start_i) begin
        pc_d    = start_pc_i;
        idx_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = S_FRZ;
      end
      S_FRZ: if (xfer) state_d = S_CID;
      S_CID: if (xfer) state_d = S_NPC;
      S_NPC: if (xfer) begin
        if (last_core) begin
          idx_d   = '0;
          state_d = S_BAR;
        end else begin
          idx_d   = idx_q + dest_width_lp'(1);
          state_d = S_FRZ;
        end
      end
      // Barrier looks at the registered count, so the first unfreeze write
      // shows up one cycle after the count has reached zero.
      S_BAR: if (cnt_q == '0) state_d = S_UNF;
      S_UNF: if (xfer) begin
        if (last_core) state_d = S_DRN;
        else           idx_d   = idx_q + dest_width_lp'(1);
      end
      S_DRN: if (cnt_q == '0) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Command outputs are registered from next-state values. Valid is gated
    // by the next count, which equals the registered count seen in the cycle
    // the command is presented; without a transfer the count can only fall,
    // so a presented command stays valid and stable until it is taken.
    dest_d = idx_d;
    addr_d = '0;
    data_d = '0;
    case (state_d)
      S_FRZ: begin addr_d = freeze_addr_p;  data_d = cfg_data_width_p'(1);     end
      S_CID: begin addr_d = core_id_addr_p; data_d = cfg_data_width_p'(idx_d); end
      S_NPC: begin addr_d = npc_addr_p;     data_d = cfg_data_width_p'(pc_d);  end
      S_UNF: begin addr_d = freeze_addr_p;  data_d = '0;                       end
      default: ;
    endcase
    cmd_v_d = (state_d inside {S_FRZ, S_CID, S_NPC, S_UNF}) && (cnt_d < max_cnt_lp);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      cmd_v_q <= 1'b0;
      dest_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cmd_v_q <= cmd_v_d;
      dest_q  <= dest_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_v_o    = cmd_v_q;
  assign cmd_dest_o = dest_q;
  assign cmd_addr_o = addr_q;
  assign cmd_data_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

`ifndef SYNTHESIS
  // An ack with no outstanding write points at a network or integration bug.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(resp_v_i && cnt_q == '0))
        else $error("bp_cfg_sequencer: ack received with no outstanding write");
    end
  end
`endif

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
module tb_bp_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [0:0]  dest;
    logic [15:0] addr;
    logic [63:0] data;
  } xfer_t;

  typedef struct {
    logic        ready;
    logic        v;
    logic [0:0]  dest;
    logic [15:0] addr;
    logic [63:0] data;
  } bpv_t;

  // ---------------- DUT A: 2 cores, 4 credits, auto acks ----------------
  logic        start_a, ready_a, resp_a;
  logic [38:0] pc_a;
  logic        v_a, busy_a, done_a;
  logic [0:0]  dest_a;
  logic [15:0] addr_a;
  logic [63:0] data_a;

  bp_cfg_sequencer #(.num_core_p(2), .max_outstanding_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_a), .start_pc_i(pc_a),
    .cmd_v_o(v_a), .cmd_ready_i(ready_a), .cmd_dest_o(dest_a), .cmd_addr_o(addr_a),
    .cmd_data_o(data_a), .resp_v_i(resp_a), .busy_o(busy_a), .done_o(done_a));

  // ---------------- DUT B: 2 cores, 2 credits, manual acks ----------------
  logic        start_b, ready_b, resp_b;
  logic [38:0] pc_b;
  logic        v_b, busy_b, done_b;
  logic [0:0]  dest_b;
  logic [15:0] addr_b;
  logic [63:0] data_b;

  bp_cfg_sequencer #(.num_core_p(2), .max_outstanding_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_b), .start_pc_i(pc_b),
    .cmd_v_o(v_b), .cmd_ready_i(ready_b), .cmd_dest_o(dest_b), .cmd_addr_o(addr_b),
    .cmd_data_o(data_b), .resp_v_i(resp_b), .busy_o(busy_b), .done_o(done_b));

  // ---------------- DUT C: single core, 1 credit ----------------
  logic        start_c, ready_c;
  logic        resp_c = 1'b0;
  logic [38:0] pc_c;
  logic        v_c, busy_c, done_c;
  logic [0:0]  dest_c;
  logic [15:0] addr_c;
  logic [63:0] data_c;

  bp_cfg_sequencer #(.num_core_p(1), .max_outstanding_p(1)) dut_c (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_c), .start_pc_i(pc_c),
    .cmd_v_o(v_c), .cmd_ready_i(ready_c), .cmd_dest_o(dest_c), .cmd_addr_o(addr_c),
    .cmd_data_o(data_c), .resp_v_i(resp_c), .busy_o(busy_c), .done_o(done_c));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- DUT A monitor: checks every transfer against the expected order ----
  xfer_t exp_a [8];
  int    xcyc  [8];
  int    xi      = 0;
  int    xi_base = 0;
  logic  seen_a  = 1'b0;
  logic  auto_ack  = 1'b1;
  logic  force_ack = 1'b0;
  logic [1:0] ack_sr = 2'b00;

  // Each transfer is acknowledged two cycles later.
  assign resp_a = (auto_ack & ack_sr[1]) | force_ack;
  always @(posedge clk) begin
    #1;
    ack_sr = {ack_sr[0], seen_a & auto_ack};
  end

  always @(negedge clk) begin
    int k;
    seen_a = v_a & ready_a;
    if (seen_a) begin
      k = xi - xi_base;
      if (k < 8) begin
        chk($sformatf("xfer%0d", k), {dest_a, addr_a, data_a},
            {exp_a[k].dest, exp_a[k].addr, exp_a[k].data});
        xcyc[k] = cyc;
      end
      xi = xi + 1;
    end
  end

  // ---- DUT B transfer counter ----
  int nb = 0;
  always @(negedge clk) if (v_b && ready_b) nb <= nb + 1;

  // ---- DUT C: ack the cycle after each transfer, log transfers ----
  logic  pend_c = 1'b0;
  xfer_t c_log [8];
  int    nc = 0;
  always @(negedge clk) begin
    pend_c <= v_c & ready_c;
    if (v_c && ready_c) begin
      if (nc < 8) c_log[nc] = '{dest_c, addr_c, data_c};
      nc = nc + 1;
    end
  end
  always @(posedge clk) begin
    #1;
    resp_c = pend_c;
  end

  task automatic fill_exp(input logic [38:0] pc);
    for (int c = 0; c < 2; c++) begin
      exp_a[3*c]   = '{c[0:0], 16'h0008, 64'd1};
      exp_a[3*c+1] = '{c[0:0], 16'h0010, 64'(c)};
      exp_a[3*c+2] = '{c[0:0], 16'h0020, 64'(pc)};
    end
    exp_a[6] = '{1'b0, 16'h0008, 64'd0};
    exp_a[7] = '{1'b1, 16'h0008, 64'd0};
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    while (!done_a && n < 200) begin tick(); n++; end
    chk(nm, done_a, 1);
  endtask

  bpv_t  bp_vec [6];
  xfer_t c_exp  [4];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cs, n;
    // Backpressure vectors: 5 stalled cycles holding CID of core 1, then ready.
    for (int k = 0; k < 5; k++) bp_vec[k] = '{1'b0, 1'b1, 1'b1, 16'h0010, 64'd1};
    bp_vec[5] = '{1'b1, 1'b1, 1'b1, 16'h0010, 64'd1};
    c_exp[0] = '{1'b0, 16'h0008, 64'd1};
    c_exp[1] = '{1'b0, 16'h0010, 64'd0};
    c_exp[2] = '{1'b0, 16'h0020, 64'h0_0000_0abc};
    c_exp[3] = '{1'b0, 16'h0008, 64'd0};

    reset_n = 1'b0;
    start_a = 0; pc_a = '0; ready_a = 1;
    start_b = 0; pc_b = '0; ready_b = 1; resp_b = 0;
    start_c = 0; pc_c = '0; ready_c = 1;
    repeat (2) tick();

    // Reset state
    chk("rst_cmd_v", v_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cmd_fields", {dest_a, addr_a, data_a}, 0);
    reset_n = 1'b1;
    tick();

    // Run 1: basic sequence
    fill_exp(39'h00_8000_0000);
    xi_base = xi;
    pc_a = 39'h00_8000_0000; start_a = 1; tick(); start_a = 0;
    cs = cyc;
    chk("busy_after_start", busy_a, 1);
    wait_done_a("run1_done");
    chk("run1_nxfer", xi - xi_base, 8);
    chk("run1_busy_clear", busy_a, 0);
    chk("first_xfer_latency", xcyc[0] - cs, 0);
    chk("pass1_back_to_back", xcyc[5] - xcyc[0], 5);
    chk("barrier_gap", xcyc[6] - xcyc[5], 4);
    chk("done_after_last_ack", cyc - xcyc[7], 4);

    // Run 2: backpressure on CID core 1, ignored start during NPC core 1
    fill_exp(39'h00_0000_1234);
    xi_base = xi;
    chk("done_sticky", done_a, 1);
    pc_a = 39'h00_0000_1234; start_a = 1; tick(); start_a = 0;
    chk("done_cleared_on_start", done_a, 0);
    n = 0;
    while (xi - xi_base < 4 && n < 50) begin tick(); n++; end
    for (int k = 0; k < 6; k++) begin
      ready_a = bp_vec[k].ready;
      @(negedge clk);
      chk($sformatf("backpressure%0d", k), {v_a, dest_a, addr_a, data_a},
          {bp_vec[k].v, bp_vec[k].dest, bp_vec[k].addr, bp_vec[k].data});
      tick();
    end
    chk("bp_xfer_on_ready", xi - xi_base, 5);
    pc_a = 39'h55_dead_beef; start_a = 1; tick(); start_a = 0; pc_a = '0;
    wait_done_a("run2_done");
    chk("run2_nxfer", xi - xi_base, 8);

    // Credit stall on DUT B (2 credits, no acks yet)
    start_b = 1; tick(); start_b = 0;
    repeat (6) tick();
    chk("cs_two_xfers", nb, 2);
    chk("cs_stalled", v_b, 0);
    resp_b = 1;
    @(negedge clk);
    chk("cs_no_same_cycle_unblock", v_b, 0);
    tick();
    chk("cs_unblock_next_cycle", v_b, 1);
    tick();                 // transfer and ack together: count stays at 1
    resp_b = 0;
    repeat (6) tick();
    chk("cs_simul_xfer_ack", nb, 4);
    chk("cs_stalled_again", v_b, 0);

    // Single-core DUT C
    pc_c = 39'h00_0000_0abc; start_c = 1; tick(); start_c = 0;
    n = 0;
    while (!done_c && n < 100) begin tick(); n++; end
    chk("single_done", done_c, 1);
    chk("single_nxfer", nc, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("single_xfer%0d", k), {c_log[k].dest, c_log[k].addr, c_log[k].data},
          {c_exp[k].dest, c_exp[k].addr, c_exp[k].data});

    // Run 3: reset in the middle of the unfreeze pass
    fill_exp(39'h00_0000_0040);
    xi_base = xi;
    pc_a = 39'h00_0000_0040; start_a = 1; tick(); start_a = 0;
    n = 0;
    while (xi - xi_base < 7 && n < 60) begin tick(); n++; end
    chk("r3_reached_unf", xi - xi_base, 7);
    ready_a = 0; auto_ack = 0; reset_n = 0; force_ack = 1;
    tick();
    reset_n = 1; force_ack = 0;
    chk("midrst_cmd_v", v_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    repeat (3) tick();
    chk("midrst_idle", {v_a, busy_a}, 0);
    ready_a = 1; auto_ack = 1;

    // Run 4: fresh start after reset completes the full sequence
    fill_exp(39'h00_0000_5000);
    xi_base = xi;
    pc_a = 39'h00_0000_5000; start_a = 1; tick(); start_a = 0;
    wait_done_a("run4_done");
    chk("run4_nxfer", xi - xi_base, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
